rgmii_tx_ddr_sched: RTL

//  Sequences the RGMII transmit output DDR registers: converts a GMII-style byte stream into per-cycle
//  d1/d2 pairs for TXD[3:0], TX_CTL and the forwarded TX clock. Runs on the 125 MHz TX clock.

---
 rtl/rgmii_tx_ddr_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rgmii_tx_ddr_sched.sv
// RGMII transmit DDR scheduler: turns a GMII byte stream into oddr d1/d2 pairs for
// TXD, TX_CTL and the forwarded TX clock at 1000M (true DDR) or 10/100M (nibble SDR).
module rgmii_tx_ddr_sched #(
  parameter int DIV_100 = 5,
  parameter int DIV_10  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       gmii_clk_en,
  output logic [3:0] txd_d1,
  output logic [3:0] txd_d2,
  output logic       ctl_d1,
  output logic       ctl_d2,
  output logic       clk_d1,
  output logic       clk_d2
);

  localparam int PMAX = (DIV_10 > DIV_100) ? DIV_10 : DIV_100;
  localparam int CW   = $clog2(PMAX);

  typedef enum logic [1:0] {
    SPD_10   = 2'b00,
    SPD_100  = 2'b01,
    SPD_1000 = 2'b10
  } speed_e;

  speed_e        spd_in, spd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] p_last, h_pt, e_pt, d_pt, d_m1;
  logic          p_odd;
  logic          nib_q, nib_d;
  logic [7:0]    byte_q, byte_d;
  logic          en_q, en_d, er_q, er_d;
  logic [3:0]    nibo_q, nibo_d;
  logic          sup_q, sup_d;
  logic          run_q;
  logic          gig, chg, strobe, ctl_v;

  assign spd_in = (speed == 2'b11) ? SPD_1000 : speed_e'(speed);
  assign gig    = (spd_q == SPD_1000);
  assign chg    = (spd_in != spd_q);

  always_comb begin
    if (spd_q == SPD_10) begin
      p_last = CW'(DIV_10 - 1);
      h_pt   = CW'(DIV_10 / 2);
      e_pt   = CW'(DIV_10 / 4);
      d_pt   = CW'((3 * DIV_10) / 4);
      p_odd  = (DIV_10 % 2) != 0;
    end else begin
      p_last = CW'(DIV_100 - 1);
      h_pt   = CW'(DIV_100 / 2);
      e_pt   = CW'(DIV_100 / 4);
      d_pt   = CW'((3 * DIV_100) / 4);
      p_odd  = (DIV_100 % 2) != 0;
    end
    d_m1 = d_pt - CW'(1);
  end

  // Strobe handshake: gmii_clk_en depends only on registered state; the byte on
  // gmii_txd/tx_en/tx_er is taken at the clock edge that ends a strobe cycle.
  assign strobe = run_q && !sup_q && (gig || (cnt_q == d_m1 && !nib_q));

  always_comb begin
    cnt_d  = cnt_q;
    nib_d  = nib_q;
    byte_d = byte_q;
    en_d   = en_q;
    er_d   = er_q;
    nibo_d = nibo_q;
    sup_d  = sup_q;
    if (gig) begin
      cnt_d  = '0;
      nib_d  = 1'b0;
      sup_d  = 1'b0;
      nibo_d = '0;
      byte_d = strobe ? gmii_txd : 8'h00;
      en_d   = strobe & gmii_tx_en;
      er_d   = strobe & gmii_tx_er;
    end else begin
      cnt_d = (cnt_q == p_last) ? '0 : cnt_q + CW'(1);
      if (cnt_q == p_last) sup_d = 1'b0;
      // Nibbles advance one period apart; suppression holds nib so the first pulse
      // after a speed change lands in the second period.
      if (cnt_q == d_m1 && !sup_q) begin
        if (!nib_q) begin
          byte_d = gmii_txd;
          en_d   = gmii_tx_en;
          er_d   = gmii_tx_er;
          nibo_d = gmii_txd[3:0];
          nib_d  = 1'b1;
        end else begin
          nibo_d = byte_q[7:4];
          nib_d  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= 1'b0;
      spd_q  <= spd_in;
      cnt_q  <= '0;
      nib_q  <= 1'b0;
      byte_q <= '0;
      en_q   <= 1'b0;
      er_q   <= 1'b0;
      nibo_q <= '0;
      sup_q  <= 1'b0;
    end else if (!run_q) begin
      run_q <= 1'b1;
      spd_q <= spd_in;
    end else if (chg) begin
      spd_q  <= spd_in;
      cnt_q  <= '0;
      nib_q  <= 1'b0;
      byte_q <= '0;
      en_q   <= 1'b0;
      er_q   <= 1'b0;
      nibo_q <= '0;
      sup_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      nib_q  <= nib_d;
      byte_q <= byte_d;
      en_q   <= en_d;
      er_q   <= er_d;
      nibo_q <= nibo_d;
      sup_q  <= sup_d;
    end
  end

  // en sits around the TX clock rise, en^er around the fall.
  assign ctl_v = (cnt_q >= d_pt || cnt_q < e_pt) ? en_q : (en_q ^ er_q);

  always_comb begin
    gmii_clk_en = 1'b0;
    txd_d1      = '0;
    txd_d2      = '0;
    ctl_d1      = 1'b0;
    ctl_d2      = 1'b0;
    clk_d1      = 1'b0;
    clk_d2      = 1'b0;
    if (run_q) begin
      gmii_clk_en = strobe;
      if (gig) begin
        txd_d1 = byte_q[3:0];
        txd_d2 = byte_q[7:4];
        ctl_d1 = en_q;
        ctl_d2 = en_q ^ er_q;
        clk_d1 = 1'b1;
        clk_d2 = 1'b0;
      end else begin
        txd_d1 = nibo_q;
        txd_d2 = nibo_q;
        ctl_d1 = ctl_v;
        ctl_d2 = ctl_v;
        clk_d1 = (cnt_q < h_pt) || (cnt_q == h_pt && p_odd);
        clk_d2 = (cnt_q < h_pt);
      end
    end
  end

endmodule
